// File: rtl/tcp_msg_poller_meta_arb.sv
// Multi-source front end for the TCP message poller: round-robin arbitration, duplicate
// check against the active bitvector, metadata write, and flowid enqueue.
module tcp_msg_poller_meta_arb #(
  parameter int NUM_SRC      = 2,
  parameter int POLLER_PTR_W = 16,
  parameter int DUP_MODE     = 0,
  parameter int CNT_W        = 16,
  parameter int FLOWID_W     = 4,
  parameter int X_W          = 8,
  parameter int Y_W          = 8,
  parameter int FBITS_W      = 4,
  parameter int MEM_W        = POLLER_PTR_W + X_W + Y_W + FBITS_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              src_msg_req_val,
  output logic [NUM_SRC-1:0]              src_msg_req_rdy,
  input  logic [NUM_SRC*FLOWID_W-1:0]     src_msg_req_flowid,
  input  logic [NUM_SRC*POLLER_PTR_W-1:0] src_msg_req_len,
  input  logic [NUM_SRC*X_W-1:0]          src_msg_dst_x,
  input  logic [NUM_SRC*Y_W-1:0]          src_msg_dst_y,
  input  logic [NUM_SRC*FBITS_W-1:0]      src_msg_dst_fbits,
  input  logic [(1<<FLOWID_W)-1:0]        meta_active_bitvec,
  output logic                            msg_req_mem_wr_val,
  output logic [FLOWID_W-1:0]             msg_req_mem_wr_addr,
  output logic [MEM_W-1:0]                msg_req_mem_wr_data,
  output logic                            msg_req_q_wr_req_val,
  output logic [FLOWID_W-1:0]             msg_req_q_wr_req_data,
  input  logic                            msg_req_q_wr_req_rdy,
  output logic                            active_bitvec_set_req_val,
  output logic [FLOWID_W-1:0]             active_bitvec_set_req_flowid,
  output logic [CNT_W-1:0]                dup_drop_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_WR_MEM = 2'd2;
  localparam logic [1:0] S_ENQ    = 2'd3;

  logic [1:0]              state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    gnt_found;
  logic [NUM_SRC-1:0]      gnt_vec;
  logic                    pend_reg;
  logic                    pend_now;
  logic [FLOWID_W-1:0]     flowid_reg;
  logic [POLLER_PTR_W-1:0] len_reg;
  logic [X_W-1:0]          x_reg;
  logic [Y_W-1:0]          y_reg;
  logic [FBITS_W-1:0]      fbits_reg;

  // Search starts one past the last winner so every source gets a turn.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!gnt_found && src_msg_req_val[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_vec          = '0;
    gnt_vec[gnt_idx] = gnt_found;
  end

  assign src_msg_req_rdy = (state == S_IDLE) ? gnt_vec : '0;
  assign pend_now        = meta_active_bitvec[flowid_reg];

  assign msg_req_mem_wr_val           = (state == S_WR_MEM);
  assign msg_req_mem_wr_addr          = flowid_reg;
  assign msg_req_mem_wr_data          = {len_reg, x_reg, y_reg, fbits_reg};
  assign msg_req_q_wr_req_val         = (state == S_ENQ);
  assign msg_req_q_wr_req_data        = flowid_reg;
  assign active_bitvec_set_req_val    = (state == S_ENQ) && msg_req_q_wr_req_rdy;
  assign active_bitvec_set_req_flowid = flowid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      rr_ptr       <= PTR_W'(NUM_SRC - 1);
      pend_reg     <= 1'b0;
      flowid_reg   <= '0;
      len_reg      <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      fbits_reg    <= '0;
      dup_drop_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            flowid_reg <= src_msg_req_flowid[int'(gnt_idx)*FLOWID_W +: FLOWID_W];
            len_reg    <= src_msg_req_len[int'(gnt_idx)*POLLER_PTR_W +: POLLER_PTR_W];
            x_reg      <= src_msg_dst_x[int'(gnt_idx)*X_W +: X_W];
            y_reg      <= src_msg_dst_y[int'(gnt_idx)*Y_W +: Y_W];
            fbits_reg  <= src_msg_dst_fbits[int'(gnt_idx)*FBITS_W +: FBITS_W];
            rr_ptr     <= gnt_idx;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          pend_reg <= pend_now;
          if (pend_now && (DUP_MODE == 0)) begin
            state <= S_IDLE;
            if (dup_drop_cnt != '1) dup_drop_cnt <= dup_drop_cnt + 1'b1;
          end else begin
            state <= S_WR_MEM;
          end
        end
        // An overwrite of a pending flow must not enqueue it a second time.
        S_WR_MEM: state <= pend_reg ? S_IDLE : S_ENQ;
        S_ENQ: if (msg_req_q_wr_req_rdy) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_msg_poller_meta_arb.sv
// Scoreboard bench: drop-mode (small counter) and overwrite-mode instances share stimulus.
module tb_tcp_msg_poller_meta_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  val;
  logic [7:0]  flowid;
  logic [31:0] len;
  logic [15:0] dx;
  logic [15:0] dy;
  logic [7:0]  dfb;
  logic [15:0] bitvec;
  logic        q_rdy;

  logic [1:0]  rdy0, rdy1;
  logic        mem_val0, mem_val1, q_val0, q_val1, set_val0, set_val1;
  logic [3:0]  mem_addr0, mem_addr1, q_data0, q_data1, set_fid0, set_fid1;
  logic [35:0] mem_data0, mem_data1;
  logic [1:0]  cnt0;
  logic [15:0] cnt1;

  tcp_msg_poller_meta_arb #(.NUM_SRC(2), .DUP_MODE(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .src_msg_req_val(val), .src_msg_req_rdy(rdy0),
    .src_msg_req_flowid(flowid), .src_msg_req_len(len), .src_msg_dst_x(dx),
    .src_msg_dst_y(dy), .src_msg_dst_fbits(dfb), .meta_active_bitvec(bitvec),
    .msg_req_mem_wr_val(mem_val0), .msg_req_mem_wr_addr(mem_addr0),
    .msg_req_mem_wr_data(mem_data0), .msg_req_q_wr_req_val(q_val0),
    .msg_req_q_wr_req_data(q_data0), .msg_req_q_wr_req_rdy(q_rdy),
    .active_bitvec_set_req_val(set_val0), .active_bitvec_set_req_flowid(set_fid0),
    .dup_drop_cnt(cnt0));

  tcp_msg_poller_meta_arb #(.NUM_SRC(2), .DUP_MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .src_msg_req_val(val), .src_msg_req_rdy(rdy1),
    .src_msg_req_flowid(flowid), .src_msg_req_len(len), .src_msg_dst_x(dx),
    .src_msg_dst_y(dy), .src_msg_dst_fbits(dfb), .meta_active_bitvec(bitvec),
    .msg_req_mem_wr_val(mem_val1), .msg_req_mem_wr_addr(mem_addr1),
    .msg_req_mem_wr_data(mem_data1), .msg_req_q_wr_req_val(q_val1),
    .msg_req_q_wr_req_data(q_data1), .msg_req_q_wr_req_rdy(q_rdy),
    .active_bitvec_set_req_val(set_val1), .active_bitvec_set_req_flowid(set_fid1),
    .dup_drop_cnt(cnt1));

  typedef struct packed { int cyc; logic [3:0] addr; logic [35:0] data; } mem_exp_t;
  typedef struct packed { int cyc; logic [3:0] fid; } push_exp_t;

  mem_exp_t  mem_q0[$], mem_q1[$];
  push_exp_t push_q0[$], push_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic mv, input logic [3:0] ma, input logic [35:0] md,
                     input logic qv, input logic [3:0] qd, input logic sv, input logic [3:0] sf);
    mem_exp_t  me;
    push_exp_t pe;
    if (mv) begin
      if ((d == 0 ? mem_q0.size() : mem_q1.size()) == 0) begin
        chk($sformatf("dut%0d unexpected mem write", d), 64'(ma), 64'hdead);
      end else begin
        me = (d == 0) ? mem_q0.pop_front() : mem_q1.pop_front();
        chk($sformatf("dut%0d mem cyc", d), 64'(cyc), 64'(me.cyc));
        chk($sformatf("dut%0d mem addr", d), 64'(ma), 64'(me.addr));
        chk($sformatf("dut%0d mem data", d), 64'(md), 64'(me.data));
      end
    end
    if (qv && q_rdy) begin
      if ((d == 0 ? push_q0.size() : push_q1.size()) == 0) begin
        chk($sformatf("dut%0d unexpected push", d), 64'(qd), 64'hdead);
      end else begin
        pe = (d == 0) ? push_q0.pop_front() : push_q1.pop_front();
        chk($sformatf("dut%0d push cyc", d), 64'(cyc), 64'(pe.cyc));
        chk($sformatf("dut%0d push fid", d), 64'(qd), 64'(pe.fid));
        chk($sformatf("dut%0d set pulse", d), 64'(sv), 64'd1);
        chk($sformatf("dut%0d set fid", d), 64'(sf), 64'(pe.fid));
      end
    end else if (sv) begin
      chk($sformatf("dut%0d stray set pulse", d), 64'(sv), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, mem_val0, mem_addr0, mem_data0, q_val0, q_data0, set_val0, set_fid0);
    mon(1, mem_val1, mem_addr1, mem_data1, q_val1, q_data1, set_val1, set_fid1);
  end

  task automatic set_src(input int s, input logic [3:0] fid, input logic [15:0] l,
                         input logic [7:0] x, input logic [7:0] y, input logic [3:0] fb);
    flowid[s*4 +: 4] = fid;
    len[s*16 +: 16]  = l;
    dx[s*8 +: 8]     = x;
    dy[s*8 +: 8]     = y;
    dfb[s*4 +: 4]    = fb;
  endtask

  // Bench model: what each instance should produce for an accepted request at cycle a.
  task automatic expect_req(input int a, input int stall, input logic [3:0] fid,
                            input logic [15:0] l, input logic [7:0] x, input logic [7:0] y,
                            input logic [3:0] fb);
    logic [35:0] d;
    d = {l, x, y, fb};
    if (!bitvec[fid]) begin
      mem_q0.push_back('{a + 1, fid, d});
      mem_q1.push_back('{a + 1, fid, d});
      push_q0.push_back('{a + 2 + stall, fid});
      push_q1.push_back('{a + 2 + stall, fid});
    end else begin
      mem_q1.push_back('{a + 1, fid, d});
      if (exp_cnt0 < 3) exp_cnt0++;
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp_gnt);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy0 == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant dut0", 64'(rdy0), 64'(exp_gnt));
    chk("grant dut1", 64'(rdy1), 64'(exp_gnt));
  endtask

  task automatic do_req(input int s, input logic [3:0] fid, input logic [15:0] l,
                        input logic [7:0] x, input logic [7:0] y, input logic [3:0] fb,
                        input int stall);
    int a;
    set_src(s, fid, l, x, y, fb);
    val[s] = 1'b1;
    if (stall > 0) q_rdy = 1'b0;
    wait_grant(2'(1 << s));
    @(posedge clk); #1;
    a = cyc;
    val = 2'b00;
    expect_req(a, stall, fid, l, x, y, fb);
    if (stall > 0) begin
      repeat (2) @(posedge clk);
      #1;
      set_src(1 - s, 4'd12, 16'd1, 8'd1, 8'd1, 4'd1);
      val[1 - s] = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall q val", 64'(q_val0), 64'd1);
        chk("stall q data", 64'(q_data0), 64'(fid));
        chk("stall no set", 64'(set_val0), 64'd0);
        chk("stall src rdy", 64'(rdy0), 64'd0);
        @(posedge clk); #1;
      end
      val   = 2'b00;
      q_rdy = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drop cnt dut0", 64'(cnt0), 64'(exp_cnt0));
    chk("drop cnt dut1", 64'(cnt1), 64'd0);
  endtask

  initial begin
    int a;
    rst = 1'b0; val = '0; flowid = '0; len = '0; dx = '0; dy = '0; dfb = '0;
    bitvec = '0; q_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem val", 64'({mem_val0, mem_val1}), 64'd0);
    chk("reset q val", 64'({q_val0, q_val1}), 64'd0);
    chk("reset set val", 64'({set_val0, set_val1}), 64'd0);
    chk("reset rdy", 64'({rdy0, rdy1}), 64'd0);
    chk("reset cnt", 64'({cnt0, cnt1}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Both sources valid continuously: grants alternate 0,1,0,1.
    set_src(0, 4'd3, 16'd30, 8'h31, 8'h32, 4'h3);
    set_src(1, 4'd7, 16'd70, 8'h71, 8'h72, 4'h7);
    val = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant((i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      a = cyc;
      if (i % 2 == 0) expect_req(a, 0, 4'd3, 16'd30, 8'h31, 8'h32, 4'h3);
      else            expect_req(a, 0, 4'd7, 16'd70, 8'h71, 8'h72, 4'h7);
    end
    val = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Single request, fixed latency.
    do_req(0, 4'd5, 16'd100, 8'hA1, 8'hB2, 4'hC, 0);

    // Pending flow: drop instance counts and saturates, overwrite instance writes only.
    bitvec[9] = 1'b1;
    do_req(0, 4'd9, 16'd40, 8'h09, 8'h19, 4'h9, 0);
    do_req(1, 4'd9, 16'd41, 8'h0A, 8'h1A, 4'hA, 0);
    do_req(0, 4'd9, 16'd42, 8'h0B, 8'h1B, 4'hB, 0);
    do_req(1, 4'd9, 16'd43, 8'h0C, 8'h1C, 4'hC, 0);
    bitvec[9] = 1'b0;

    // Queue backpressure for 5 cycles.
    do_req(1, 4'd14, 16'd500, 8'h55, 8'h66, 4'h2, 5);

    // Reset while holding in ENQ.
    q_rdy = 1'b0;
    set_src(1, 4'd2, 16'd22, 8'h22, 8'h23, 4'h4);
    val[1] = 1'b1;
    wait_grant(2'b10);
    @(posedge clk); #1;
    a = cyc;
    val = 2'b00;
    mem_q0.push_back('{a + 1, 4'd2, {16'd22, 8'h22, 8'h23, 4'h4}});
    mem_q1.push_back('{a + 1, 4'd2, {16'd22, 8'h22, 8'h23, 4'h4}});
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("enq before reset", 64'({q_val0, q_val1}), 64'b11);
    #1;
    rst = 1'b0;
    exp_cnt0 = 0;
    #1;
    chk("reset q val immediate", 64'({q_val0, q_val1}), 64'd0);
    chk("reset set immediate", 64'({set_val0, set_val1}), 64'd0);
    chk("reset cnt after", 64'(cnt0), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    set_src(0, 4'd1, 16'd11, 8'h11, 8'h12, 4'h1);
    set_src(1, 4'd6, 16'd66, 8'h61, 8'h62, 4'h6);
    val = 2'b11;
    wait_grant(2'b01);
    @(posedge clk); #1;
    a = cyc;
    val = 2'b00;
    expect_req(a, 0, 4'd1, 16'd11, 8'h11, 8'h12, 4'h1);
    repeat (8) @(posedge clk);
    #1;

    chk("mem q0 drained", 64'(mem_q0.size()), 64'd0);
    chk("mem q1 drained", 64'(mem_q1.size()), 64'd0);
    chk("push q0 drained", 64'(push_q0.size()), 64'd0);
    chk("push q1 drained", 64'(push_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
